// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch stage: register index, datapath width
// and the forwarding-bus record used by the bypass network.
package operand_fetch_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        dest;
    logic [XLEN-1:0] data;
  } fwd_bus_t;

  // x0 is hard-wired to zero, so a producer targeting it never forwards.
  function automatic logic bus_hits(input fwd_bus_t bus, input reg_idx_t src);
    return bus.valid && (bus.dest != '0) && (bus.dest == src);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Priority operand select for one source: x0, then EX, MEM, WB, register file.
module operand_bypass
  import operand_fetch_pkg::*;
(
  input  reg_idx_t        src,
  input  logic [XLEN-1:0] rf_data,
  input  fwd_bus_t        ex,
  input  logic            ex_is_load,
  input  fwd_bus_t        mem,
  input  fwd_bus_t        wb,
  output logic [XLEN-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (src == '0) begin
      operand = '0;
    end else if (bus_hits(ex, src) && !ex_is_load) begin
      // A load in EX has no data yet; that case is resolved by stalling.
      operand = ex.data;
    end else if (bus_hits(mem, src)) begin
      operand = mem.data;
    end else if (bus_hits(wb, src)) begin
      operand = wb.data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch pipeline stage: reads the register file, applies bypassing,
// stalls on load-use hazards and holds one instruction for the execute stage.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // Handshakes (in_* and out_*): a transfer happens on a rising edge where
  // valid && ready; the sender keeps payload stable while valid && !ready.
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic [$clog2(REGS)-1:0] in_src_a,
  input  logic [$clog2(REGS)-1:0] in_src_b,
  input  logic [$clog2(REGS)-1:0] in_dest,
  input  logic                    in_uses_a,
  input  logic                    in_uses_b,
  input  logic                    in_is_load,
  output logic [$clog2(REGS)-1:0] rf_src_a,
  output logic [$clog2(REGS)-1:0] rf_src_b,
  input  logic [XLEN-1:0]         rf_reg_a,
  input  logic [XLEN-1:0]         rf_reg_b,
  input  logic                    ex_fwd_valid,
  input  logic [$clog2(REGS)-1:0] ex_fwd_dest,
  input  logic [XLEN-1:0]         ex_fwd_data,
  input  logic                    ex_fwd_is_load,
  input  logic                    mem_fwd_valid,
  input  logic [$clog2(REGS)-1:0] mem_fwd_dest,
  input  logic [XLEN-1:0]         mem_fwd_data,
  input  logic                    wb_load,
  input  logic [$clog2(REGS)-1:0] wb_dest,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [XLEN-1:0]         out_op_a,
  output logic [XLEN-1:0]         out_op_b,
  output logic [$clog2(REGS)-1:0] out_dest,
  output logic                    out_is_load,
  output logic [15:0]             stall_count
);

  fwd_bus_t        ex_bus;
  fwd_bus_t        mem_bus;
  fwd_bus_t        wb_bus;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hazard;
  logic            accept;

  assign rf_src_a = in_src_a;
  assign rf_src_b = in_src_b;

  assign ex_bus  = '{valid: ex_fwd_valid,  dest: ex_fwd_dest,  data: ex_fwd_data};
  assign mem_bus = '{valid: mem_fwd_valid, dest: mem_fwd_dest, data: mem_fwd_data};
  assign wb_bus  = '{valid: wb_load,       dest: wb_dest,      data: wb_data};

  operand_bypass u_bypass_a (
    .src        (in_src_a),
    .rf_data    (rf_reg_a),
    .ex         (ex_bus),
    .ex_is_load (ex_fwd_is_load),
    .mem        (mem_bus),
    .wb         (wb_bus),
    .operand    (op_a)
  );

  operand_bypass u_bypass_b (
    .src        (in_src_b),
    .rf_data    (rf_reg_b),
    .ex         (ex_bus),
    .ex_is_load (ex_fwd_is_load),
    .mem        (mem_bus),
    .wb         (wb_bus),
    .operand    (op_b)
  );

  assign hazard = ex_fwd_valid && ex_fwd_is_load && (ex_fwd_dest != '0) &&
                  ((in_uses_a && (in_src_a == ex_fwd_dest)) ||
                   (in_uses_b && (in_src_b == ex_fwd_dest)));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Payload registers load only on accept, so they hold through stalls,
  // bubbles and flushes; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_dest    <= '0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_op_a    <= op_a;
      out_op_b    <= op_b;
      out_dest    <= in_dest;
      out_is_load <= in_is_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (in_valid && hazard && !flush && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed bypass table, hand-written stall,
// backpressure, flush and reset sequences, then a randomized run.
module tb_operand_fetch;

  localparam int W = 32 + 32 + 32 + 5 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_src_a, in_src_b, in_dest;
  logic        in_uses_a, in_uses_b, in_is_load;
  logic [4:0]  rf_src_a, rf_src_b;
  logic [31:0] rf_reg_a, rf_reg_b;
  logic        ex_fwd_valid, ex_fwd_is_load;
  logic [4:0]  ex_fwd_dest;
  logic [31:0] ex_fwd_data;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_dest;
  logic [31:0] mem_fwd_data;
  logic        wb_load;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_op_a, out_op_b;
  logic [4:0]  out_dest;
  logic        out_is_load;
  logic [15:0] stall_count;

  logic [31:0] regs [32];
  int checks   = 0;
  int failures = 0;

  assign rf_reg_a = regs[rf_src_a];
  assign rf_reg_b = regs[rf_src_b];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dest(in_dest),
    .in_uses_a(in_uses_a), .in_uses_b(in_uses_b), .in_is_load(in_is_load),
    .rf_src_a(rf_src_a), .rf_src_b(rf_src_b),
    .rf_reg_a(rf_reg_a), .rf_reg_b(rf_reg_b),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_dest(ex_fwd_dest),
    .ex_fwd_data(ex_fwd_data), .ex_fwd_is_load(ex_fwd_is_load),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data),
    .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_dest(out_dest),
    .out_is_load(out_is_load), .stall_count(stall_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid = 0; in_pc = '0; in_src_a = '0; in_src_b = '0; in_dest = '0;
    in_uses_a = 0; in_uses_b = 0; in_is_load = 0;
    ex_fwd_valid = 0; ex_fwd_dest = '0; ex_fwd_data = '0; ex_fwd_is_load = 0;
    mem_fwd_valid = 0; mem_fwd_dest = '0; mem_fwd_data = '0;
    wb_load = 0; wb_dest = '0; wb_data = '0;
    flush = 0; out_ready = 1;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] sa, input logic [4:0] sb,
                             input logic [4:0] dst, input logic ua, input logic ub);
    in_valid = 1; in_pc = pc; in_src_a = sa; in_src_b = sb; in_dest = dst;
    in_uses_a = ua; in_uses_b = ub; in_is_load = pc[2];
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  src_a, src_b;
    logic        ex_v, ex_ld;
    logic [4:0]  ex_d;
    logic [31:0] ex_data;
    logic        mem_v;
    logic [4:0]  mem_d;
    logic [31:0] mem_data;
    logic        wb_v;
    logic [4:0]  wb_d;
    logic [31:0] wb_data;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [9];

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  logic         model_valid;
  logic [15:0]  model_stall;

  function automatic logic [31:0] ref_operand(input logic [4:0] src);
    if (src == 0) return 32'd0;
    if (ex_fwd_valid && !ex_fwd_is_load && ex_fwd_dest == src) return ex_fwd_data;
    if (mem_fwd_valid && mem_fwd_dest == src) return mem_fwd_data;
    if (wb_load && wb_dest == src) return wb_data;
    return regs[src];
  endfunction

  function automatic logic [W-1:0] out_word();
    return {out_pc, out_op_a, out_op_b, out_dest, out_is_load};
  endfunction

  initial begin
    logic        hz, rdy, acc, xfer;
    logic [31:0] pc_before;

    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    regs[0] = 32'hDEAD_BEEF;
    regs[5] = 32'h0000_1234;
    regs[6] = 32'h0000_6666;
    regs[7] = 32'h0000_7777;

    //            sa  sb  exv exld exd exdata   memv memd memdata  wbv wbd wbdata   exp_a         exp_b
    vecs[0] = '{5'd5, 5'd6, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'h1234,     32'h6666};
    vecs[1] = '{5'd5, 5'd6, 1, 0, 5'd5, 32'hA,  1, 5'd5, 32'hB,  1, 5'd5, 32'hC,  32'hA,        32'h6666};
    vecs[2] = '{5'd5, 5'd6, 0, 0, 5'd5, 32'hA,  1, 5'd5, 32'hB,  1, 5'd5, 32'hC,  32'hB,        32'h6666};
    vecs[3] = '{5'd5, 5'd6, 0, 0, 5'd5, 32'hA,  0, 5'd5, 32'hB,  1, 5'd5, 32'hC,  32'hC,        32'h6666};
    vecs[4] = '{5'd5, 5'd0, 1, 0, 5'd0, 32'hFF, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'h1234,     32'h0};
    vecs[5] = '{5'd5, 5'd6, 1, 1, 5'd5, 32'hA,  1, 5'd5, 32'hB,  0, 5'd0, 32'h0,  32'hB,        32'h6666};
    vecs[6] = '{5'd6, 5'd5, 1, 0, 5'd6, 32'h11, 1, 5'd5, 32'h22, 0, 5'd0, 32'h0,  32'h11,       32'h22};
    vecs[7] = '{5'd0, 5'd0, 0, 0, 5'd0, 32'h0,  1, 5'd0, 32'h33, 1, 5'd0, 32'h44, 32'h0,        32'h0};
    vecs[8] = '{5'd5, 5'd7, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd5, 32'hC,  32'h1234,     32'h7777};

    // ---- reset ----
    drive_idle();
    rst = 1;
    step();
    #1 check("in_ready_in_reset", W'(in_ready), W'(1));
    step();
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_outputs", out_word(), '0);
    check("reset_stall", W'(stall_count), W'(0));
    rst = 0;

    // ---- directed bypass table ----
    for (int i = 0; i < 9; i++) begin
      drive_instr(32'h100 + 32'(4 * i), vecs[i].src_a, vecs[i].src_b, 5'(i), 0, 0);
      ex_fwd_valid = vecs[i].ex_v; ex_fwd_is_load = vecs[i].ex_ld;
      ex_fwd_dest = vecs[i].ex_d; ex_fwd_data = vecs[i].ex_data;
      mem_fwd_valid = vecs[i].mem_v; mem_fwd_dest = vecs[i].mem_d; mem_fwd_data = vecs[i].mem_data;
      wb_load = vecs[i].wb_v; wb_dest = vecs[i].wb_d; wb_data = vecs[i].wb_data;
      #1 check($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(1));
      step();
      drive_idle();
      #1;
      check($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(1));
      check($sformatf("vec%0d_op_a", i), W'(out_op_a), W'(vecs[i].exp_a));
      check($sformatf("vec%0d_op_b", i), W'(out_op_b), W'(vecs[i].exp_b));
      check($sformatf("vec%0d_pc", i), W'(out_pc), W'(32'h100 + 32'(4 * i)));
    end
    step();

    // ---- load-use stall ----
    drive_instr(32'h180, 5'd7, 5'd1, 5'd9, 1, 0);
    ex_fwd_valid = 1; ex_fwd_is_load = 1; ex_fwd_dest = 5'd7; ex_fwd_data = 32'h5555;
    #1 check("lu_in_ready_low", W'(in_ready), W'(0));
    step();
    check("lu_bubble", W'(out_valid), W'(0));
    check("lu_stall_count", W'(stall_count), W'(1));
    ex_fwd_valid = 0; ex_fwd_is_load = 0;
    #1 check("lu_in_ready_high", W'(in_ready), W'(1));
    step();
    drive_idle();
    check("lu_accept_valid", W'(out_valid), W'(1));
    check("lu_accept_op_a", W'(out_op_a), W'(32'h7777));
    check("lu_stall_hold", W'(stall_count), W'(1));

    // ---- backpressure ----
    drive_instr(32'h200, 5'd5, 5'd6, 5'd3, 1, 1);
    step();
    drive_instr(32'h300, 5'd6, 5'd5, 5'd4, 1, 1);
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      mem_fwd_valid = 1; mem_fwd_dest = 5'd5; mem_fwd_data = $urandom;
      #1 check($sformatf("bp%0d_in_ready", c), W'(in_ready), W'(0));
      step();
      check($sformatf("bp%0d_hold", c), out_word(),
            {32'h200, 32'h1234, 32'h6666, 5'd3, 1'b0});
      check($sformatf("bp%0d_valid", c), W'(out_valid), W'(1));
    end
    mem_fwd_valid = 0;
    out_ready = 1;
    #1 check("bp_release_ready", W'(in_ready), W'(1));
    step();
    drive_idle();
    check("bp_next_accept", out_word(), {32'h300, 32'h6666, 32'h1234, 5'd4, 1'b0});

    // ---- flush with in_valid ----
    drive_instr(32'h304, 5'd5, 5'd5, 5'd2, 0, 0);
    out_ready = 0; flush = 1;
    #1 check("flush_in_ready", W'(in_ready), W'(0));
    step();
    check("flush_out_valid", W'(out_valid), W'(0));
    check("flush_data_kept", W'(out_pc), W'(32'h300));
    drive_idle();

    // ---- reset mid-transfer, over flush and accept ----
    drive_instr(32'h404, 5'd5, 5'd6, 5'd8, 0, 0);
    step();
    check("pre_rst_valid", W'(out_valid), W'(1));
    out_ready = 0; flush = 1; rst = 1;
    step();
    check("rst_mid_valid", W'(out_valid), W'(0));
    check("rst_mid_outputs", out_word(), '0);
    check("rst_mid_stall", W'(stall_count), W'(0));
    drive_idle();
    #1 check("rst_in_ready", W'(in_ready), W'(1));
    step();
    rst = 0;

    // ---- randomized run against the reference model ----
    model_valid = 0;
    model_stall = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_out_valid", W'(out_valid), W'(model_valid));
      if (model_valid && exp_q.size() > 0) check("rnd_payload", out_word(), exp_q[0]);
      check("rnd_stall", W'(stall_count), W'(model_stall));

      in_valid = ($urandom_range(3) != 0);
      in_pc = $urandom; in_src_a = 5'($urandom_range(7)); in_src_b = 5'($urandom_range(7));
      in_dest = 5'($urandom_range(31)); in_uses_a = 1'($urandom); in_uses_b = 1'($urandom);
      in_is_load = 1'($urandom);
      ex_fwd_valid = 1'($urandom); ex_fwd_dest = 5'($urandom_range(7)); ex_fwd_data = $urandom;
      ex_fwd_is_load = ($urandom_range(3) == 0);
      mem_fwd_valid = 1'($urandom); mem_fwd_dest = 5'($urandom_range(7)); mem_fwd_data = $urandom;
      wb_load = 1'($urandom); wb_dest = 5'($urandom_range(7)); wb_data = $urandom;
      flush = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(3) != 0);
      #1;

      hz = ex_fwd_valid && ex_fwd_is_load && ex_fwd_dest != 0 &&
           ((in_uses_a && in_src_a == ex_fwd_dest) || (in_uses_b && in_src_b == ex_fwd_dest));
      rdy = (!model_valid || out_ready) && !hz && !flush;
      acc = in_valid && rdy;
      xfer = model_valid && out_ready;
      check("rnd_in_ready", W'(in_ready), W'(rdy));
      check("rnd_rf_idx", W'({rf_src_a, rf_src_b}), W'({in_src_a, in_src_b}));

      if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
      if (flush) begin
        model_valid = 0;
        exp_q.delete();
      end else if (acc) begin
        exp_q.push_back({in_pc, ref_operand(in_src_a), ref_operand(in_src_b), in_dest, in_is_load});
        model_valid = 1;
      end else if (out_ready) begin
        model_valid = 0;
      end
      if (in_valid && hz && !flush && model_stall != 16'hFFFF) model_stall++;
      step();
    end

    pc_before = out_pc;
    drive_idle();
    step();
    check("final_idle_valid", W'(out_valid), W'(0));
    check("final_data_kept", W'(out_pc), W'(pc_before));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
